// File: rtl/sixty_four_bit_divider.sv
// Sequential signed restoring divider for the Y86 execute stage.
// One quotient bit per cycle through a single shared subtractor.
module sixty_four_bit_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Register every piece of state; reset returns to an idle, all-zero view.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            count_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            count_q     <= count_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state, datapath step and registered-output values.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        count_d     = count_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        // The partial remainder stays below the divisor magnitude (<= 2^63),
        // so its top bit is always clear and the shift never loses data.
        rem_sh = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        trial  = {1'b0, rem_sh} - {1'b0, dvs_q};
        a_mag  = dividend[WIDTH-1] ? -dividend : dividend;
        b_mag  = divisor[WIDTH-1] ? -divisor : divisor;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    rem_d      = '0;
                    dvd_d      = a_mag;
                    dvs_d      = b_mag;
                    count_d    = LAST_BIT;
                    neg_quo_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d  = dividend[WIDTH-1];
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = ALL_ONES;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                    end else if (dividend == MIN_NEG && divisor == ALL_ONES) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = MIN_NEG;
                        remainder_d = '0;
                        overflow_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                if (count_q == '0) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            FIX: begin
                quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                done_d      = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sixty_four_bit_divider.sv
// Self-checking bench for sixty_four_bit_divider.
// Vector table, handshake/reset sequences and random ops vs. a model.
module tb_sixty_four_bit_divider;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    sixty_four_bit_divider #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Signed division as the language defines it: truncation toward zero,
    // remainder taking the dividend's sign; exceptions handled up front.
    task automatic model(input logic signed [63:0] a,
                         input logic signed [63:0] b,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic dz, output logic ov);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (a == MINV && b == -64'sd1) begin
            q  = MINV;
            r  = '0;
            ov = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen at a negedge.
    task automatic wait_done(input bit disturb, output int lat,
                             output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (disturb) begin
                start    = (lat == 9 || lat == 63);
                dividend = {$urandom, $urandom};
                divisor  = {$urandom, $urandom};
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic run_vec(input string t, input vec_t v);
        int lat;
        bit bok;
        int exp_lat;
        exp_lat = (v.dz || v.ov) ? 0 : 65;
        issue(v.a, v.b);
        wait_done(1'b0, lat, bok);
        chk({t, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({t, ".busy"}, 64'(bok), 64'd1);
        chk({t, ".quotient"}, quotient, v.q);
        chk({t, ".remainder"}, remainder, v.r);
        chk({t, ".div_zero"}, 64'(div_zero), 64'(v.dz));
        chk({t, ".overflow"}, 64'(overflow), 64'(v.ov));
        @(posedge clk);
        @(negedge clk);
        chk({t, ".done_pulse"}, 64'(done), 64'd0);
        chk({t, ".busy_fall"}, 64'(busy), 64'd0);
        chk({t, ".q_hold"}, quotient, v.q);
        chk({t, ".flag_hold"}, 64'({div_zero, overflow}),
            64'({v.dz, v.ov}));
    endtask

    initial begin
        vec_t v;
        int   lat;
        bit   bok;
        int   pulses;

        tbl[0]  = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0};
        tbl[1]  = '{-64'd100, 64'd7, -64'd14, -64'd2, 1'b0, 1'b0};
        tbl[2]  = '{64'd100, -64'd7, -64'd14, 64'd2, 1'b0, 1'b0};
        tbl[3]  = '{-64'd100, -64'd7, 64'd14, -64'd2, 1'b0, 1'b0};
        tbl[4]  = '{64'd5, 64'd0, '1, 64'd5, 1'b1, 1'b0};
        tbl[5]  = '{MINV, '1, MINV, 64'd0, 1'b0, 1'b1};
        tbl[6]  = '{'1, 64'd1, '1, 64'd0, 1'b0, 1'b0};
        tbl[7]  = '{MAXV, MAXV, 64'd1, 64'd0, 1'b0, 1'b0};
        tbl[8]  = '{MINV, 64'd2, 64'hC000_0000_0000_0000, 64'd0, 1'b0, 1'b0};
        tbl[9]  = '{MINV, MINV, 64'd1, 64'd0, 1'b0, 1'b0};
        tbl[10] = '{64'd7, 64'd100, 64'd0, 64'd7, 1'b0, 1'b0};
        tbl[11] = '{-64'd7, -64'd100, 64'd0, -64'd7, 1'b0, 1'b0};
        tbl[12] = '{-64'd9, 64'd0, '1, -64'd9, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.quotient", quotient, 64'd0);
        chk("reset.remainder", remainder, 64'd0);
        chk("reset.flags", 64'({div_zero, overflow}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Ignored starts and operand churn during CALC, then a start in DONE.
        issue(64'd1000, 64'd33);
        wait_done(1'b1, lat, bok);
        chk("hs.latency", 64'(lat), 64'd65);
        chk("hs.busy", 64'(bok), 64'd1);
        chk("hs.quotient", quotient, 64'd30);
        chk("hs.remainder", remainder, 64'd10);
        start    = 1'b1;
        dividend = 64'd9;
        divisor  = 64'd3;
        @(posedge clk);
        @(negedge clk);
        chk("hs.start_in_done", 64'(busy), 64'd0);
        chk("hs.q_after_done", quotient, 64'd30);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b0, lat, bok);
        chk("hs.next.latency", 64'(lat), 64'd65);
        chk("hs.next.quotient", quotient, 64'd3);
        chk("hs.next.remainder", remainder, 64'd0);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of CALC.
        issue(64'd1000, 64'd7);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.quotient", quotient, 64'd0);
        chk("rst.remainder", remainder, 64'd0);
        chk("rst.flags", 64'({div_zero, overflow}), 64'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (80) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("rst.no_done", 64'(pulses), 64'd0);
        v = '{64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 1'b0};
        run_vec("rst.fresh", v);

        // Random operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            v.a = {$urandom, $urandom};
            v.b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: v.b = '0;
                1: begin
                    v.a = MINV;
                    v.b = '1;
                end
                2: v.b = 64'($urandom_range(1, 20));
                3: v.b = -64'($urandom_range(1, 20));
                4: v.a = 64'($urandom_range(0, 1000));
                5: v.b = 64'($urandom) >> $urandom_range(0, 31);
                default: ;
            endcase
            model(v.a, v.b, v.q, v.r, v.dz, v.ov);
            run_vec($sformatf("rnd%0d", i), v);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
